// File: rtl/gen2_pkg.sv
// rtl/gen2_pkg.sv - shared types and constants for the Gen2 preamble encoder
package gen2_pkg;

    localparam logic [1:0] M_FM0 = 2'd0;
    localparam logic [1:0] M_M2  = 2'd1;
    localparam logic [1:0] M_M4  = 2'd2;
    localparam logic [1:0] M_M8  = 2'd3;

    typedef enum logic [1:0] {
        SYM0 = 2'd0,
        SYM1 = 2'd1,
        SYMV = 2'd2
    } sym_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int PRE_LEN = 6;

    // Preamble bodies after the pilot, first symbol in the most significant slot
    localparam logic [2*PRE_LEN-1:0] FM0_PRE = {SYM1, SYM0, SYM1, SYM0, SYMV, SYM1};
    localparam logic [2*PRE_LEN-1:0] MIL_PRE = {SYM0, SYM1, SYM0, SYM1, SYM1, SYM1};

endpackage

// File: rtl/gen2_preamble_symbol_seq.sv
// rtl/gen2_preamble_symbol_seq.sv - maps encoding/pilot/symbol index to symbol type and tick count
module gen2_preamble_symbol_seq
    import gen2_pkg::*;
#(
    parameter int FM0_PILOT_LONG  = 12,
    parameter int MIL_PILOT_SHORT = 4,
    parameter int MIL_PILOT_LONG  = 16,
    parameter int SYM_W           = 5
) (
    input  logic [1:0]       i_m,
    input  logic             i_trext,
    input  logic [SYM_W-1:0] i_sym_idx,
    output sym_t             o_sym,
    output logic             o_last,
    output logic [4:0]       o_ticks
);

    logic [SYM_W-1:0] w_pilot;
    logic [SYM_W-1:0] w_off;
    logic             w_fm0;

    assign w_fm0 = (i_m == M_FM0);
    assign w_off = i_sym_idx - w_pilot;

    // Pilot length and ticks per symbol for the selected encoding
    always_comb begin
        w_pilot = '0;
        o_ticks = 5'd2;
        if (w_fm0) begin
            w_pilot = i_trext ? SYM_W'(FM0_PILOT_LONG) : '0;
        end else begin
            w_pilot = i_trext ? SYM_W'(MIL_PILOT_LONG) : SYM_W'(MIL_PILOT_SHORT);
            o_ticks = 5'd2 << i_m;
        end
    end

    // Pilot symbols are data-0; afterwards index into the fixed preamble body
    always_comb begin
        o_sym = SYM0;
        if (i_sym_idx >= w_pilot) begin
            for (int j = 0; j < PRE_LEN; j++) begin
                if (w_off == SYM_W'(j)) begin
                    o_sym = w_fm0 ? sym_t'(FM0_PRE[2*(PRE_LEN-1-j) +: 2])
                                  : sym_t'(MIL_PRE[2*(PRE_LEN-1-j) +: 2]);
                end
            end
        end
        o_last = (i_sym_idx == w_pilot + SYM_W'(PRE_LEN - 1));
    end

endmodule

// File: rtl/gen2_preamble_encoder.sv
// rtl/gen2_preamble_encoder.sv - FM0/Miller preamble waveform generator with start/busy/done handshake
module gen2_preamble_encoder
    import gen2_pkg::*;
#(
    parameter int FM0_PILOT_LONG  = 12,
    parameter int MIL_PILOT_SHORT = 4,
    parameter int MIL_PILOT_LONG  = 16,
    parameter int SYM_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       m,
    input  logic             trext,
    input  logic             blf_tick,
    input  logic             abort,
    output logic             tx,
    output logic             violation,
    output logic             busy,
    output logic             done,
    output logic             end_level,
    output logic [SYM_W-1:0] sym_idx
);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_m;
    logic             r_trext;
    logic [SYM_W-1:0] r_sym;
    logic [3:0]       r_k;
    logic             r_f;
    logic             r_b;
    logic             r_prev;
    logic             r_tx;
    logic             r_viol;
    logic             r_done;
    logic             r_end;

    sym_t             w_sym;
    logic             w_last;
    logic [4:0]       w_ticks;
    logic             w_is_fm0;
    logic             w_k_last;
    logic             w_f_next;
    logic             w_b_next;
    logic             w_mil_flip;

    gen2_preamble_symbol_seq #(
        .FM0_PILOT_LONG (FM0_PILOT_LONG),
        .MIL_PILOT_SHORT(MIL_PILOT_SHORT),
        .MIL_PILOT_LONG (MIL_PILOT_LONG),
        .SYM_W          (SYM_W)
    ) u_seq (
        .i_m      (r_m),
        .i_trext  (r_trext),
        .i_sym_idx(r_sym),
        .o_sym    (w_sym),
        .o_last   (w_last),
        .o_ticks  (w_ticks)
    );

    assign w_is_fm0 = (r_m == M_FM0);
    assign w_k_last = ({1'b0, r_k} == (w_ticks - 5'd1));

    // FM0: boundary flip except into V (the violation); data-0 adds a mid-symbol flip
    assign w_f_next = (r_k == 4'd0) ? ((w_sym == SYMV) ? r_f : ~r_f)
                                    : ((w_sym == SYM0) ? ~r_f : r_f);

    // Miller: flip between consecutive data-0s, and mid-symbol on data-1
    assign w_mil_flip = ((r_k == 4'd0) && !r_prev && (w_sym == SYM0)) ||
                        ((r_k == w_ticks[4:1]) && (w_sym == SYM1));
    assign w_b_next   = r_b ^ w_mil_flip;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (blf_tick && w_k_last && w_last) w_state_next = ST_FIN;
            ST_FIN:  if (blf_tick) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (abort) w_state_next = ST_IDLE;
    end

    // Datapath: latch config on start, advance encoder phase and counters on each tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m     <= '0;
            r_trext <= 1'b0;
            r_sym   <= '0;
            r_k     <= '0;
            r_f     <= 1'b0;
            r_b     <= 1'b0;
            r_prev  <= 1'b1;
            r_tx    <= 1'b0;
            r_viol  <= 1'b0;
            r_done  <= 1'b0;
            r_end   <= 1'b0;
        end else if (abort) begin
            r_tx   <= 1'b0;
            r_viol <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= m;
                        r_trext <= trext;
                        r_sym   <= '0;
                        r_k     <= '0;
                        r_f     <= 1'b0;
                        r_b     <= 1'b0;
                        r_prev  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (blf_tick) begin
                        if (w_is_fm0) begin
                            r_f    <= w_f_next;
                            r_tx   <= w_f_next;
                            r_viol <= (w_sym == SYMV);
                        end else begin
                            r_b    <= w_b_next;
                            r_tx   <= w_b_next ^ r_k[0];
                        end
                        if (w_k_last) begin
                            r_k    <= '0;
                            r_prev <= (w_sym == SYM1);
                            if (!w_last) r_sym <= r_sym + SYM_W'(1);
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                    end
                end
                ST_FIN: begin
                    if (blf_tick) begin
                        r_done <= 1'b1;
                        r_viol <= 1'b0;
                        r_end  <= w_is_fm0 ? r_f : r_b;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        tx        = r_tx;
        violation = r_viol;
        busy      = (r_state != ST_IDLE);
        done      = r_done;
        end_level = r_end;
        sym_idx   = r_sym;
    end

endmodule

// File: tb/tb_gen2_preamble_encoder.sv
// tb/tb_gen2_preamble_encoder.sv - scoreboard bench for gen2_preamble_encoder
module tb_gen2_preamble_encoder;

    logic       clk = 1'b0;
    logic       reset, start, trext, blf_tick, abort;
    logic [1:0] m;
    logic       tx, violation, busy, done, end_level;
    logic [4:0] sym_idx;

    gen2_preamble_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .m        (m),
        .trext    (trext),
        .blf_tick (blf_tick),
        .abort    (abort),
        .tx       (tx),
        .violation(violation),
        .busy     (busy),
        .done     (done),
        .end_level(end_level),
        .sym_idx  (sym_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit tx;
        bit viol;
        bit lvl;
    } exp_t;

    exp_t expq[$];
    bit   cap[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_seen = 0;
    int   exp_n;
    int   exp_ticks;
    bit   exp_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: build symbol list, then render the waveform half-period by half-period
    task automatic build(input int mm, input bit tr);
        int   syms[$];
        int   fm0_body[6] = '{1, 0, 1, 0, 2, 1};
        int   mil_body[6] = '{0, 1, 0, 1, 1, 1};
        int   p;
        int   half;
        int   prevs;
        bit   lvl;
        exp_t e;
        p = (mm == 0) ? (tr ? 12 : 0) : (tr ? 16 : 4);
        repeat (p) syms.push_back(0);
        for (int i = 0; i < 6; i++) syms.push_back(mm == 0 ? fm0_body[i] : mil_body[i]);
        exp_n = syms.size();
        exp_ticks = 0;
        lvl = 1'b0;
        e.is_done = 1'b0;
        e.lvl = 1'b0;
        if (mm == 0) begin
            foreach (syms[i]) begin
                if (syms[i] != 2) lvl = ~lvl;
                e.tx = lvl; e.viol = (syms[i] == 2); expq.push_back(e); exp_ticks++;
                if (syms[i] == 0) lvl = ~lvl;
                e.tx = lvl; e.viol = (syms[i] == 2); expq.push_back(e); exp_ticks++;
            end
        end else begin
            half = 1 << mm;
            prevs = 1;
            foreach (syms[i]) begin
                if (syms[i] == 0 && prevs == 0) lvl = ~lvl;
                for (int t = 0; t < 2 * half; t++) begin
                    if (syms[i] == 1 && t == half) lvl = ~lvl;
                    e.tx = lvl ^ t[0]; e.viol = 1'b0; expq.push_back(e); exp_ticks++;
                end
                prevs = syms[i];
            end
        end
        e.is_done = 1'b1; e.viol = 1'b0; e.lvl = lvl;
        e.tx = expq[expq.size()-1].tx;
        expq.push_back(e);
        exp_end = lvl;
    endtask

    // Monitor: every tick that lands while busy consumes one expected item
    initial begin
        bit   pt, pb, pa;
        exp_t e;
        forever begin
            @(negedge clk);
            pt = blf_tick; pb = busy; pa = abort;
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
            if (pt && pb && !pa && !reset) begin
                if (expq.size() == 0) begin
                    chk("unexpected_tick", 1, 0);
                end else begin
                    e = expq.pop_front();
                    if (e.is_done) begin
                        chk("done_pulse", done, 1);
                        chk("busy_after_done", busy, 0);
                        chk("end_level", end_level, e.lvl);
                        chk("tx_hold", tx, e.tx);
                        chk("viol_after_done", violation, 0);
                    end else begin
                        cap.push_back(tx);
                        chk("tx", tx, e.tx);
                        chk("violation", violation, e.viol);
                    end
                end
            end
        end
    end

    task automatic run_burst(input int mm, input bit tr, input bit disturb);
        int ticks = 0;
        int cyc = 0;
        bit last_tick = 1'b0;
        done_seen = 0;
        cap.delete();
        build(mm, tr);
        m = 2'(mm); trext = tr; start = 1'b1;
        blf_tick = 1'($urandom_range(0, 1));
        step();
        start = 1'b0; blf_tick = 1'b0;
        while (done_seen == 0 && cyc < 6000) begin
            blf_tick = !last_tick && ($urandom_range(0, 2) != 0);
            if (blf_tick && busy) ticks++;
            if (disturb && busy) begin
                start = 1'($urandom_range(0, 1));
                m = 2'($urandom);
                trext = 1'($urandom);
            end
            step();
            last_tick = blf_tick;
            cyc++;
        end
        blf_tick = 1'b0; start = 1'b0; m = 2'(mm); trext = tr;
        chk("done_timeout", done_seen != 0, 1);
        repeat (3) step();
        chk("done_count", done_seen, 1);
        chk("tick_count", ticks, exp_ticks + 1);
        chk("queue_drained", expq.size(), 0);
        chk("sym_idx_hold", sym_idx, exp_n - 1);
        chk("end_level_hold", end_level, exp_end);
        chk("busy_idle", busy, 0);
        expq.delete();
    endtask

    task automatic chk_cap(input string name, input logic [63:0] pat, input int n);
        bit ok = 1'b1;
        if (cap.size() < n) ok = 1'b0;
        else for (int i = 0; i < n; i++) if (cap[i] !== pat[n-1-i]) ok = 1'b0;
        chk(name, ok, 1);
    endtask

    initial begin
        logic [63:0] pat;
        bit          prev_end;
        int          cyc;
        reset = 1'b1; start = 1'b0; m = 2'd0; trext = 1'b0; blf_tick = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_tx", tx, 0);
        chk("reset_violation", violation, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_end_level", end_level, 0);
        chk("reset_sym_idx", sym_idx, 0);
        reset = 1'b0;
        step();

        run_burst(0, 0, 0);
        pat = 64'b110100100011;
        chk_cap("fm0_short_pattern", pat, 12);
        chk("fm0_end_level", end_level, 1);

        run_burst(0, 1, 0);
        pat = {28'd0, {12{2'b10}}, 12'b110100100011};
        chk_cap("fm0_long_pattern", pat, 36);

        run_burst(1, 0, 0);
        pat = 64'b01011010;
        chk_cap("m2_first8", pat, 8);
        chk("m2_end_level", end_level, 0);

        run_burst(3, 1, 0);
        chk("m8_long_sym_idx", sym_idx, 21);

        run_burst(0, 0, 1);
        pat = 64'b110100100011;
        chk_cap("fm0_disturbed_pattern", pat, 12);
        run_burst(2, 0, 1);

        // Abort partway through Miller symbol 3, with start and tick also raised
        prev_end = end_level;
        done_seen = 0;
        build(2, 0);
        m = 2'd2; trext = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (sym_idx != 5'd3 && cyc < 2000) begin
            blf_tick = ~blf_tick; step(); cyc++;
        end
        chk("abort_reach_sym3", sym_idx, 3);
        blf_tick = 1'b0; step();
        blf_tick = 1'b1; step();
        blf_tick = 1'b0; step();
        if (tx == 1'b0) begin blf_tick = 1'b1; step(); blf_tick = 1'b0; step(); end
        chk("abort_pre_tx", tx, 1);
        abort = 1'b1; blf_tick = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx", tx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_violation", violation, 0);
        #1;
        abort = 1'b0; blf_tick = 1'b0; start = 1'b0;
        expq.delete();
        repeat (10) begin blf_tick = ~blf_tick; step(); end
        blf_tick = 1'b0;
        chk("abort_no_done", done_seen, 0);
        chk("abort_end_level_kept", end_level, prev_end);
        chk("abort_stays_idle", busy, 0);
        run_burst(2, 0, 0);

        // Asynchronous reset in the middle of a burst
        build(0, 1);
        m = 2'd0; trext = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) begin blf_tick = ~blf_tick; step(); end
        blf_tick = 1'b0;
        chk("reset_pre_busy", busy, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {tx, violation, busy, done, end_level, sym_idx}, 0);
        expq.delete();
        step(); step();
        reset = 1'b0;
        step();

        repeat (4) run_burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen2_preamble_encoder.md
Name: gen2_preamble_encoder

Overview:
- Parametrised next-generation EPC Gen2 tag-to-reader preamble generator.
- Emits the fully encoded baseband waveform, one half-BLF period per tick, for FM0 and Miller M=2/4/8, with optional TRext pilot.
- Runs a start/busy/done handshake and hands its final encoder phase to the downstream data encoder.
- Sits between the reply sequencer and the backscatter modulator driver.

Parameters:
- FM0_PILOT_LONG, 12, FM0 leading data-0 symbols when trext=1 (0 when trext=0).
- MIL_PILOT_SHORT, 4, Miller pilot data-0 symbols when trext=0.
- MIL_PILOT_LONG, 16, Miller pilot data-0 symbols when trext=1.
- SYM_W, 5, symbol index width; must hold max(pilot)+6-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request burst; sampled only when idle
- m  in  2  0=FM0, 1=M2, 2=M4, 3=M8; latched on start
- trext  in  1  long pilot select; latched on start
- blf_tick  in  1  one-clk pulse per half BLF period
- abort  in  1  synchronous cancel
- tx  out  1  encoded baseband
- violation  out  1  high while the FM0 V symbol is being emitted
- busy  out  1  burst in progress
- done  out  1  one-clk pulse at burst end
- end_level  out  1  final FM0 level F / Miller level B, valid from done until next start
- sym_idx  out  SYM_W  current symbol index

Behaviour:
- Reset: tx=0, violation=0, busy=0, done=0, end_level=0, sym_idx=0. FSM=IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE with start=1: latch m and trext; busy=1 at that edge; clear symbol and tick counters; F=0, B=0, prev=1.
  - blf_tick on the same cycle as start is ignored.
- Symbol sequence:
  - FM0: P pilot 0s, then 1,0,1,0,V,1.
  - Miller: P pilot 0s, then 0,1,0,1,1,1.
  - P comes from the parameters per m/trext.
  - N = P + 6 symbols.
- Ticks per symbol: K = 2 for FM0, 2M for Miller (4/8/16). Tick index k runs 0..K-1.
- FM0 encoding, per tick in RUN:
  - k=0: invert F, then tx=F.
  - k=1: data-0 inverts F; data-1 and V hold F; then tx=F.
  - violation=1 during both V ticks.
- Miller encoding, per tick in RUN:
  - k=0: if prev=0 and the current symbol is 0, invert B.
  - k=M with a data-1 symbol: invert B.
  - tx = B XOR k[0].
  - At the end of the symbol, prev = current symbol.
- Counter rules:
  - tx and violation update only on blf_tick edges.
  - k wraps at K-1, then sym_idx increments.
  - After the last tick of symbol N-1, FSM moves to FIN and sym_idx holds at N-1 (no wrap).
- FIN: the next blf_tick finishes the last half-period.
  - At that edge: done=1 for one clk, busy=0, violation=0, end_level=F or B, FSM=IDLE.
  - tx holds its last value until the next start.
- Latency: first tx value is driven on the first blf_tick after start. Total driven ticks = N*K. done occurs on tick N*K+1.
- start while busy: ignored. m/trext changes during a burst: ignored.
- abort (any state): next edge IDLE, tx=0, violation=0, busy=0, no done, end_level unchanged. abort has priority over start and blf_tick.
- Asynchronous reset mid-burst: immediate return to reset values.

Decomposition:
- Package gen2_pkg holds:
  - m codes (M_FM0, M_M2, M_M4, M_M8)
  - FM0 and Miller preamble symbol constants
  - symbol type enum (SYM0, SYM1, SYMV)
  - FSM state encoding
- One natural sub-module: gen2_preamble_symbol_seq. It is combinational: (m, trext, sym_idx) -> symbol type, last-symbol flag, K.

Test Plan:
- FM0, trext=0, tick every 4 clk: tx over ticks 1..12 = 1 1 0 1 0 0 1 0 0 0 1 1. violation high on ticks 9-10. done on tick 13. end_level=1.
- FM0, trext=1: 24 pilot ticks alternating 1 0 1 0…, then the 12-tick pattern above. done on tick 37.
- Miller M=2, trext=0: first 8 ticks 0 1 0 1 1 0 1 0. Total 40 ticks. done on tick 41. end_level=0.
- Miller M=8, trext=1: 22 symbols x 16 = 352 ticks. sym_idx stops at 21. done once.
- start pulsed while busy, and m toggled mid-burst -> waveform identical to an undisturbed run.
- abort at Miller symbol 3 -> tx=0 and busy=0 next clk, no done pulse. A following start produces a clean full preamble. reset asserted mid-burst gives all outputs 0 asynchronously.
